dmem_responder: RTL and testbench
=================================

# dmem_responder

Data-memory responder for the single-cycle/pipelined RISC-V core: the target end of the load/store interface driven by the memory-access stage. Accepts one word-addressed request (chip enable, write enable, byte enables, address, write data), inserts a fixed number of wait states, then commits the write or returns read data with a one-cycle response pulse. Flags misaligned and out-of-range accesses instead of touching storage.

## Interface
- `DEPTH_WORDS`, 1024: storage depth in 32-bit words; power of two.
- `WAIT_CYCLES`, 2: wait states between acceptance and response; 0..15.
- `BASE_ADDR`, 32'h0000_0000: byte address of word 0.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  reset, synchronous, active-high.
- `req_ce`  in  1  request valid (memory chip enable).
- `req_we`  in  1  1 = store, 0 = load.
- `req_be`  in  4  byte-lane write enables, lane i = bits 8i+7:8i (little-endian).
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  store data.
- `req_ready`  out  1  responder can accept a request this cycle.
- `rsp_valid`  out  1  one-cycle response pulse.
- `rsp_rdata`  out  32  load data; 0 for stores and errors.
- `rsp_err`  out  1  access rejected (misaligned or out of range); valid with `rsp_valid`.

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE: `req_ready`=1. Edge with `req_ce`=1 accepts. `req_we`, `req_be`, `req_addr`, `req_wdata` are captured into internal registers. Next state is WAIT when WAIT_CYCLES>0, otherwise RESP. Edge with `req_ce`=0 stays in IDLE.
- WAIT: `req_ready`=0. A 4-bit counter loads WAIT_CYCLES-1 on acceptance and decrements each cycle. At 0, the next state is RESP. Requester inputs are ignored in this state.
- Error check on the captured address:
  - misaligned when addr[1:0]≠0;
  - out of range when (addr−BASE_ADDR)>>2 ≥ DEPTH_WORDS, using unsigned 32-bit subtraction so addresses below the base wrap and are out of range.
- Commit occurs on the edge entering RESP:
  - no error, store: write each lane whose `req_be` bit is set; other lanes unchanged. `be`=4'b0000 is a legal no-op store.
  - no error, load: register the full word into `rsp_rdata`. `be` is ignored for loads.
  - error: no storage access; `rsp_rdata`=0, `rsp_err`=1.
- RESP: `rsp_valid`=1 for exactly one cycle, `req_ready`=0, then return to IDLE.
- Reset values: state IDLE, `req_ready`=1 on the cycle after reset, `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0, counter 0. Storage contents are not reset.
- Reset during WAIT aborts the access: no write is committed and no response is produced. Reset on the edge entering RESP wins over the commit.

## Timing
- Acceptance at edge k. `rsp_valid` is high in cycle k+WAIT_CYCLES+1, and the store is visible from that cycle.
- Next acceptance is possible at edge k+WAIT_CYCLES+2, so throughput is one access per WAIT_CYCLES+2 cycles.
- All outputs are registered; there is no combinational path from inputs to outputs. `req_ready` is decoded from the registered state.
- `rsp_rdata` and `rsp_err` hold their values until the next RESP cycle. They are only meaningful while `rsp_valid`=1.
- Read-after-write to the same address, issued back-to-back, returns the new data. This follows from the store committing before the next acceptance.

## Structure
- Shared package `dmem_pkg`:
  - state enum `dmem_state_t` {IDLE, WAIT, RESP};
  - constants for word width (32) and byte-lane count (4).
- Sub-module `dmem_array`: single-port synchronous word RAM with per-byte write enable and a registered read. It has no reset and holds DEPTH_WORDS×32 bits. The FSM, counter, capture registers and error checks stay in `dmem_responder`.

## Test plan
- Reset with default parameters: `req_ready`=1, `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0 → first request accepted on the first post-reset edge.
- Store 32'hDEADBEEF to 0x10 with be=4'hF, then load from 0x10 → `rsp_valid` pulses 3 cycles after each acceptance, load returns 32'hDEADBEEF with `rsp_err`=0.
- Store 32'h000000AA to 0x10 with be=4'b0001, then load from 0x10 → 32'hDEADBEAA.
- Load from 0x13 (misaligned), then load from BASE_ADDR+4·DEPTH_WORDS (out of range) → `rsp_err`=1, `rsp_rdata`=0, storage unchanged.
- Assert rst one cycle after accepting a store of 32'h12345678 to 0x20, then load from 0x20 → no response for the aborted store, load returns the prior contents.
- WAIT_CYCLES=0, `req_ce` held high continuously → `rsp_valid` every second cycle, `req_ready` alternating 1/0, data correct on each response.

Source files
------------

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and constants
// for the data-memory responder slice.
package dmem_pkg;

  localparam int XLEN   = 32;
  localparam int NLANES = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_t;

endpackage

// File: rtl/dmem_array.sv
// dmem_array: single-port word RAM with
// per-byte write enable and registered read.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = 10
) (
  input  logic              clk,
  input  logic              en_i,
  input  logic              we_i,
  input  logic [NLANES-1:0] be_i,
  input  logic [AW-1:0]     addr_i,
  input  logic [XLEN-1:0]   wdata_i,
  output logic [XLEN-1:0]   rdata_o
);

  logic [XLEN-1:0] mem_q [DEPTH_WORDS];
  logic [XLEN-1:0] rdata_q;

  // byte-lane write or full-word registered read
  always_ff @(posedge clk) begin
    if (en_i) begin
      if (we_i) begin
        for (int i = 0; i < NLANES; i++) begin
          if (be_i[i]) begin
            mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
          end
        end
      end else begin
        rdata_q <= mem_q[addr_i];
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: load/store target with fixed
// wait states, error flagging and one-cycle response.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter int          WAIT_CYCLES = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_ce,
  input  logic              req_we,
  input  logic [NLANES-1:0] req_be,
  input  logic [XLEN-1:0]   req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  output logic              req_ready,
  output logic              rsp_valid,
  output logic [XLEN-1:0]   rsp_rdata,
  output logic              rsp_err
);

  localparam int AW = (DEPTH_WORDS > 1) ?
                      $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0] WLOAD =
    (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  dmem_state_t       state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              we_q;
  logic [NLANES-1:0] be_q;
  logic [XLEN-1:0]   addr_q;
  logic [XLEN-1:0]   wdata_q;
  logic              err_q;
  logic              ld_q;

  logic              idle;
  logic              a_we;
  logic [NLANES-1:0] a_be;
  logic [XLEN-1:0]   a_addr;
  logic [XLEN-1:0]   a_wdata;
  logic [XLEN-1:0]   off;
  logic              a_err;
  logic              commit;
  logic              ram_en;
  logic [XLEN-1:0]   ram_rdata;

  // with zero wait states the commit edge is also
  // the accept edge, so use live inputs in IDLE
  always_comb begin
    idle    = (state_q == IDLE);
    a_we    = idle ? req_we    : we_q;
    a_be    = idle ? req_be    : be_q;
    a_addr  = idle ? req_addr  : addr_q;
    a_wdata = idle ? req_wdata : wdata_q;
    off     = a_addr - BASE_ADDR;
    a_err   = (|a_addr[1:0]) ||
              ((off >> 2) >= 32'(DEPTH_WORDS));
    commit  = (idle && req_ce && (WAIT_CYCLES == 0)) ||
              ((state_q == WAIT) && (cnt_q == 4'd0));
    ram_en  = commit && !a_err && !rst;
  end

  // next-state and wait counter
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (req_ce) begin
          cnt_d = WLOAD;
          if (WAIT_CYCLES > 0) state_d = WAIT;
          else                 state_d = RESP;
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) state_d = RESP;
        else               cnt_d   = cnt_q - 4'd1;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // control state and response flags
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      err_q   <= 1'b0;
      ld_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (commit) begin
        err_q <= a_err;
        ld_q  <= !a_err && !a_we;
      end
    end
  end

  // request capture on acceptance
  always_ff @(posedge clk) begin
    if (idle && req_ce) begin
      we_q    <= req_we;
      be_q    <= req_be;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
    end
  end

  dmem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_array (
    .clk     (clk),
    .en_i    (ram_en),
    .we_i    (a_we),
    .be_i    (a_be),
    .addr_i  (off[AW+1:2]),
    .wdata_i (a_wdata),
    .rdata_o (ram_rdata)
  );

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign rsp_err   = err_q;
  assign rsp_rdata = ld_q ? ram_rdata : '0;

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed checks for
// dmem_responder with 2 and 0 wait states.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        a_ce = 1'b0;
  logic        a_we = 1'b0;
  logic [3:0]  a_be = 4'h0;
  logic [31:0] a_addr = '0;
  logic [31:0] a_wd = '0;
  logic        a_ready, a_valid, a_err;
  logic [31:0] a_rdata;

  logic        b_ce = 1'b0;
  logic        b_we = 1'b0;
  logic [3:0]  b_be = 4'h0;
  logic [31:0] b_addr = '0;
  logic [31:0] b_wd = '0;
  logic        b_ready, b_valid, b_err;
  logic [31:0] b_rdata;

  int nerr = 0;
  int nchk = 0;

  always #5 clk = ~clk;

  dmem_responder #(
    .DEPTH_WORDS (1024),
    .WAIT_CYCLES (2),
    .BASE_ADDR   (32'h0)
  ) dut_a (
    .clk       (clk),
    .rst       (rst),
    .req_ce    (a_ce),
    .req_we    (a_we),
    .req_be    (a_be),
    .req_addr  (a_addr),
    .req_wdata (a_wd),
    .req_ready (a_ready),
    .rsp_valid (a_valid),
    .rsp_rdata (a_rdata),
    .rsp_err   (a_err)
  );

  dmem_responder #(
    .DEPTH_WORDS (1024),
    .WAIT_CYCLES (0),
    .BASE_ADDR   (32'h0)
  ) dut_b (
    .clk       (clk),
    .rst       (rst),
    .req_ce    (b_ce),
    .req_we    (b_we),
    .req_be    (b_be),
    .req_addr  (b_addr),
    .req_wdata (b_wd),
    .req_ready (b_ready),
    .rsp_valid (b_valid),
    .rsp_rdata (b_rdata),
    .rsp_err   (b_err)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h",
             tag, obs, exp);
    end
  endtask

  // caller is at a negedge; ends at a negedge
  task automatic txn_a(input string tag,
                       input logic we,
                       input logic [3:0] be,
                       input logic [31:0] addr,
                       input logic [31:0] wd,
                       input logic [31:0] exp_rd,
                       input logic exp_err);
    int lat;
    logic [31:0] rd;
    logic er;
    lat = 0;
    rd  = '0;
    er  = 1'b0;
    a_ce = 1'b1;
    a_we = we;
    a_be = be;
    a_addr = addr;
    a_wd = wd;
    @(posedge clk);
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      if (n == 1) a_ce = 1'b0;
      if (a_valid && lat == 0) begin
        lat = n;
        rd  = a_rdata;
        er  = a_err;
        break;
      end
    end
    chk({tag, "_lat"}, 32'(lat), 32'd3);
    chk({tag, "_rdata"}, rd, exp_rd);
    chk({tag, "_err"}, {31'd0, er}, {31'd0, exp_err});
    @(negedge clk);
    chk({tag, "_vld_lo"}, {31'd0, a_valid}, 32'd0);
    chk({tag, "_rdy_hi"}, {31'd0, a_ready}, 32'd1);
  endtask

  logic        ops_we   [7];
  logic [3:0]  ops_be   [7];
  logic [31:0] ops_addr [7];
  logic [31:0] ops_wd   [7];
  logic [31:0] ops_rd   [7];
  logic        ops_err  [7];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int pulses;

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_ready", {31'd0, a_ready}, 32'd1);
    chk("rst_valid", {31'd0, a_valid}, 32'd0);
    chk("rst_rdata", a_rdata, 32'd0);
    chk("rst_err", {31'd0, a_err}, 32'd0);

    txn_a("st_full", 1'b1, 4'hF, 32'h10,
          32'hDEADBEEF, 32'h0, 1'b0);
    txn_a("ld_full", 1'b0, 4'h0, 32'h10,
          32'h0, 32'hDEADBEEF, 1'b0);
    txn_a("st_lane0", 1'b1, 4'b0001, 32'h10,
          32'h000000AA, 32'h0, 1'b0);
    txn_a("ld_lane0", 1'b0, 4'hF, 32'h10,
          32'h0, 32'hDEADBEAA, 1'b0);
    txn_a("ld_misal", 1'b0, 4'hF, 32'h13,
          32'h0, 32'h0, 1'b1);
    txn_a("ld_oor", 1'b0, 4'hF, 32'h1000,
          32'h0, 32'h0, 1'b1);
    txn_a("st_misal", 1'b1, 4'hF, 32'h11,
          32'h0, 32'h0, 1'b1);
    txn_a("st_oor", 1'b1, 4'hF, 32'h1010,
          32'h0, 32'h0, 1'b1);
    txn_a("ld_intact", 1'b0, 4'h0, 32'h10,
          32'h0, 32'hDEADBEAA, 1'b0);
    txn_a("st_be0", 1'b1, 4'h0, 32'h10,
          32'hFFFFFFFF, 32'h0, 1'b0);
    txn_a("ld_be0", 1'b0, 4'h0, 32'h10,
          32'h0, 32'hDEADBEAA, 1'b0);
    txn_a("st_prior", 1'b1, 4'hF, 32'h20,
          32'hCAFEF00D, 32'h0, 1'b0);

    a_ce = 1'b1;
    a_we = 1'b1;
    a_be = 4'hF;
    a_addr = 32'h20;
    a_wd = 32'h12345678;
    @(posedge clk);
    @(negedge clk);
    a_ce = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      if (a_valid) pulses++;
      @(negedge clk);
    end
    chk("abort_pulses", 32'(pulses), 32'd0);
    chk("abort_ready", {31'd0, a_ready}, 32'd1);
    txn_a("ld_abort", 1'b0, 4'hF, 32'h20,
          32'h0, 32'hCAFEF00D, 1'b0);

    ops_we[0] = 1'b1; ops_be[0] = 4'hF;
    ops_addr[0] = 32'h0; ops_wd[0] = 32'h11223344;
    ops_rd[0] = 32'h0; ops_err[0] = 1'b0;
    ops_we[1] = 1'b0; ops_be[1] = 4'h0;
    ops_addr[1] = 32'h0; ops_wd[1] = 32'h0;
    ops_rd[1] = 32'h11223344; ops_err[1] = 1'b0;
    ops_we[2] = 1'b1; ops_be[2] = 4'b1100;
    ops_addr[2] = 32'h0; ops_wd[2] = 32'hAABBCCDD;
    ops_rd[2] = 32'h0; ops_err[2] = 1'b0;
    ops_we[3] = 1'b0; ops_be[3] = 4'hF;
    ops_addr[3] = 32'h0; ops_wd[3] = 32'h0;
    ops_rd[3] = 32'hAABB3344; ops_err[3] = 1'b0;
    ops_we[4] = 1'b0; ops_be[4] = 4'hF;
    ops_addr[4] = 32'h2; ops_wd[4] = 32'h0;
    ops_rd[4] = 32'h0; ops_err[4] = 1'b1;
    ops_we[5] = 1'b0; ops_be[5] = 4'hF;
    ops_addr[5] = 32'h0; ops_wd[5] = 32'h0;
    ops_rd[5] = 32'hAABB3344; ops_err[5] = 1'b0;
    ops_we[6] = 1'b0; ops_be[6] = 4'hF;
    ops_addr[6] = 32'h1000; ops_wd[6] = 32'h0;
    ops_rd[6] = 32'h0; ops_err[6] = 1'b1;

    b_ce = 1'b1;
    for (int i = 0; i < 7; i++) begin
      chk($sformatf("b%0d_rdy_hi", i),
          {31'd0, b_ready}, 32'd1);
      chk($sformatf("b%0d_vld_lo", i),
          {31'd0, b_valid}, 32'd0);
      b_we = ops_we[i];
      b_be = ops_be[i];
      b_addr = ops_addr[i];
      b_wd = ops_wd[i];
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("b%0d_vld_hi", i),
          {31'd0, b_valid}, 32'd1);
      chk($sformatf("b%0d_rdy_lo", i),
          {31'd0, b_ready}, 32'd0);
      chk($sformatf("b%0d_rdata", i),
          b_rdata, ops_rd[i]);
      chk($sformatf("b%0d_err", i),
          {31'd0, b_err}, {31'd0, ops_err[i]});
      @(negedge clk);
    end
    b_ce = 1'b0;

    $display("Result: errors=%0d of %0d checks",
             nerr, nchk);
    $finish;
  end

endmodule
